// File: rtl/load_store_unit_if.sv
// Processor/memory handshake bundle for load_store_unit; the slave modport is the
// LSU view and the master modport is the processor plus data-memory view.
interface load_store_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misaligned;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        r_w;
    logic [31:0] mem_out;

    modport master (
        output req, we, size, sgn, addr, wdata, mem_out,
        input  busy, done, misaligned, rdata, mem_addr, mem_data, r_w
    );

    modport slave (
        input  req, we, size, sgn, addr, wdata, mem_out,
        output busy, done, misaligned, rdata, mem_addr, mem_data, r_w
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit against a big-endian word memory. Sub-word stores
// read-modify-write the containing word; misaligned or illegal-size accesses finish in ERR.
module load_store_unit #(
    parameter int ALIGN_CHECK = 1
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;

    state_t      state;
    logic        we_q;
    logic        sgn_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        mis;
    logic [1:0]  off_in;

    // Lane offset is force-aligned per size so ALIGN_CHECK=0 ignores the low bits.
    always_comb begin
        mis    = 1'b0;
        off_in = 2'b00;
        case (bus.size)
            2'b00: off_in = bus.addr[1:0];
            2'b01: begin
                off_in = {bus.addr[1], 1'b0};
                mis    = (ALIGN_CHECK != 0) && bus.addr[0];
            end
            2'b10: mis = (ALIGN_CHECK != 0) && (bus.addr[1:0] != 2'b00);
            default: mis = 1'b1;
        endcase
    end

    // Big-endian lanes: byte offset k sits at bits [31-8k : 24-8k].
    function automatic logic [4:0] lane_shift(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   return 5'd24 - {off, 3'b000};
            2'b01:   return off[1] ? 5'd0 : 5'd16;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic s);
        logic [31:0] t;
        t = w >> lane_shift(sz, off);
        case (sz)
            2'b00:   return {{24{s & t[7]}}, t[7:0]};
            2'b01:   return {{16{s & t[15]}}, t[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [4:0]  sh;
        logic [31:0] m;
        sh = lane_shift(sz, off);
        case (sz)
            2'b00:   m = 32'h0000_00FF << sh;
            2'b01:   m = 32'h0000_FFFF << sh;
            default: m = '1;
        endcase
        return (w & ~m) | ((d << sh) & m);
    endfunction

    assign bus.mem_data = (state == WRITE) ? merge(word_q, wdata_q, size_q, off_q) : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            sgn_q          <= 1'b0;
            size_q         <= 2'b00;
            off_q          <= 2'b00;
            wdata_q        <= 32'h0;
            word_q         <= 32'h0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.r_w        <= 1'b0;
            bus.rdata      <= 32'h0;
            bus.mem_addr   <= 32'h0;
        end else begin
            bus.done       <= 1'b0;
            bus.misaligned <= 1'b0;
            bus.r_w        <= 1'b0;
            case (state)
                IDLE: if (bus.req) begin
                    we_q         <= bus.we;
                    sgn_q        <= bus.sgn;
                    size_q       <= bus.size;
                    off_q        <= off_in;
                    wdata_q      <= bus.wdata;
                    bus.mem_addr <= {bus.addr[31:2], 2'b00};
                    bus.busy     <= 1'b1;
                    if (mis) begin
                        state          <= ERR;
                        bus.done       <= 1'b1;
                        bus.misaligned <= 1'b1;
                    end else if (bus.we && bus.size == 2'b10) begin
                        state   <= WRITE;
                        bus.r_w <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    word_q <= bus.mem_out;
                    if (we_q) begin
                        state   <= WRITE;
                        bus.r_w <= 1'b1;
                    end else begin
                        state     <= DONE;
                        bus.done  <= 1'b1;
                        bus.rdata <= extract(bus.mem_out, size_q, off_q, sgn_q);
                    end
                end
                WRITE: begin
                    state    <= DONE;
                    bus.done <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Random and directed load/store traffic against a byte-addressed big-endian reference memory.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_en = 1'b0;

    load_store_unit_if bus ();

    load_store_unit #(.ALIGN_CHECK(1)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0]  ref_mem [0:1023];
    logic [31:0] dmem    [0:255];
    logic [31:0] exp_rdata = 32'h0;
    int          n_tests = 0;
    int          n_fail  = 0;

    assign bus.mem_out = dmem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++)
                dmem[i] <= {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]};
        end else if (bus.r_w) begin
            dmem[bus.mem_addr[9:2]] <= bus.mem_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_model(input int a);
        return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    endfunction

    // Big-endian: lowest address is the most significant byte of the value.
    function automatic logic [31:0] ld_model(input int a, input int n, input logic s);
        logic [31:0] v;
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[a+i]);
        if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic st_model(input int a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) ref_mem[a+i] = 8'(d >> (8*(n-1-i)));
    endtask

    task automatic do_op(input logic w, input logic [1:0] sz, input logic s,
                         input logic [31:0] a, input logic [31:0] wd);
        int n, lat, nrw, exp_lat;
        logic em;
        logic [31:0] ea, eload, eword;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        em  = (sz == 2'd3) || (a % n != 0);
        ea  = a & ~32'd3;
        eload = ld_model(int'(a), n, s);
        exp_lat = em ? 1 : !w ? 2 : (sz == 2'd2) ? 2 : 3;
        if (w && !em) st_model(int'(a), n, wd);
        eword = word_model(int'(ea));
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sgn = s; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.req = 1'b0;
        lat = 1; nrw = 0;
        while (!bus.done && lat < 8) begin
            if (bus.r_w) begin
                nrw++;
                chk("wr_addr", bus.mem_addr, ea);
                chk("wr_data", bus.mem_data, eword);
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("done", 32'(bus.done), 32'd1);
        chk("latency", lat, exp_lat);
        chk("misaligned", 32'(bus.misaligned), 32'(em));
        chk("rw_count", nrw, (w && !em) ? 1 : 0);
        chk("rw_at_done", 32'(bus.r_w), 32'd0);
        if (!w && !em) exp_rdata = eload;
        chk("rdata", bus.rdata, exp_rdata);
        @(posedge clk); #1;
        chk("idle_after_done", {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int errs, c, first, prev, gaps_bad, nd;
        logic [31:0] w0;
        bus.req = 0; bus.we = 0; bus.size = 0; bus.sgn = 0; bus.addr = 0; bus.wdata = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
        ref_mem[256] = 8'h11; ref_mem[257] = 8'h22; ref_mem[258] = 8'h33; ref_mem[259] = 8'hF4;
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_mis", 32'(bus.misaligned), 0);
        chk("rst_rw", 32'(bus.r_w), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_data", bus.mem_data, 0);
        init_en = 1'b1;
        @(posedge clk); #1;
        init_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Directed scenarios
        do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        chk("ld_byte_sext", bus.rdata, 32'hFFFF_FFF4);
        do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        chk("ld_byte_zext", bus.rdata, 32'h0000_00F4);
        do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344);
        do_op(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_ABCD);
        chk("st_half_mem", dmem[64], 32'h1122_ABCD);
        do_op(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF);
        chk("st_word_mem", dmem[128], 32'hDEAD_BEEF);
        do_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
        do_op(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
        do_op(1'b1, 2'd3, 1'b0, 32'h104, 32'h1234_5678);

        for (int k = 0; k < 60; k++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            do_op(1'($urandom), sz, 1'($urandom), 32'($urandom_range(0, 1023)), $urandom);
        end

        errs = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== word_model(4*i)) errs++;
        chk("mem_image", errs, 0);

        // Back-to-back loads with req held high
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd0; bus.sgn = 1'b1; bus.addr = 32'h103;
        first = -1; prev = -1; gaps_bad = 0; nd = 0;
        for (c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                nd++;
                if (first < 0) first = c;
                else if (c - prev != 3) gaps_bad++;
                prev = c;
            end
        end
        @(negedge clk);
        bus.req = 1'b0;
        chk("b2b_first_done", first, 2);
        chk("b2b_pulses", nd, 3);
        chk("b2b_spacing", gaps_bad, 0);
        exp_rdata = ld_model(32'h103, 1, 1'b1);
        chk("b2b_rdata", bus.rdata, exp_rdata);
        @(posedge clk); #1;
        chk("b2b_idle", 32'(bus.busy), 0);

        // Reset while the WRITE cycle of a sub-word store is on the bus
        w0 = word_model(32'h300);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd1; bus.sgn = 1'b0;
        bus.addr = 32'h302; bus.wdata = ~{16'h0, w0[15:0]};
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        chk("rst_wr_rw_pre", 32'(bus.r_w), 1);
        reset = 1'b1;
        #1;
        chk("rst_wr_rw", 32'(bus.r_w), 0);
        chk("rst_wr_busy", 32'(bus.busy), 0);
        chk("rst_wr_done", 32'(bus.done), 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) nd++;
        end
        chk("rst_wr_no_done", nd, 0);
        chk("rst_wr_mem", dmem[192], w0);
        exp_rdata = 32'h0;
        do_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
